// File: rtl/apb_manager_fsm.sv
// Single-manager APB bridge: request channel -> region decode -> SETUP/ACCESS, response channel back.
// Hit: rspValid 3 cycles after accept plus wait states; miss: next cycle. One request in flight, reqReady only in IDLE.
module apb_manager_fsm #(
    parameter int                   AddrWidth     = 32,
    parameter int                   DataWidth     = 32,
    parameter int                   PrphNum       = 4,
    parameter logic [AddrWidth-1:0] BaseAddr      = '0,
    parameter int                   RegionBits    = 12,
    parameter int                   TimeoutCycles = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     reqValid,
    output logic                     reqReady,
    input  logic [AddrWidth-1:0]     reqAddr,
    input  logic                     reqWrite,
    input  logic [DataWidth-1:0]     reqWData,
    input  logic [DataWidth/8-1:0]   reqStrb,
    input  logic [3:0]               reqProt,
    output logic                     rspValid,
    input  logic                     rspReady,
    output logic [DataWidth-1:0]     rspRData,
    output logic                     rspError,
    output logic                     rspTimeout,
    output logic [AddrWidth-1:0]     addr,
    output logic [3:0]               prot,
    output logic                     write,
    output logic [DataWidth-1:0]     wData,
    output logic [DataWidth/8-1:0]   strb,
    output logic [PrphNum-1:0]       selectors,
    output logic                     enable,
    input  logic                     ready,
    input  logic [DataWidth-1:0]     rData,
    input  logic                     subError
);

    localparam int StrbW     = DataWidth / 8;
    localparam int WaitW     = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam int WaitLastI = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;
    localparam logic [WaitW-1:0] WaitLast = WaitLastI[WaitW-1:0];

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]           r_state;
    logic [WaitW-1:0]     r_wait;
    logic [AddrWidth-1:0] r_addr;
    logic [3:0]           r_prot;
    logic                 r_write;
    logic [DataWidth-1:0] r_wdata;
    logic [StrbW-1:0]     r_strb;
    logic [PrphNum-1:0]   r_sel;
    logic [DataWidth-1:0] r_rdata;
    logic                 r_err;
    logic                 r_to;

    logic [AddrWidth-1:0] w_offset;
    logic [AddrWidth-1:0] w_index;
    logic                 w_hit;
    logic [PrphNum-1:0]   w_sel;

    // Offset wraps for addresses below BaseAddr; the explicit compare rejects those.
    always_comb begin
        w_offset = reqAddr - BaseAddr;
        w_index  = w_offset >> RegionBits;
        w_hit    = (reqAddr >= BaseAddr) && (w_index < AddrWidth'(PrphNum));
        for (int i = 0; i < PrphNum; i++) begin
            w_sel[i] = (w_index == AddrWidth'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_wait  <= '0;
            r_addr  <= '0;
            r_prot  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_sel   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (reqValid) begin
                        if (w_hit) begin
                            r_state <= SETUP;
                            r_wait  <= '0;
                            r_addr  <= reqAddr;
                            r_prot  <= reqProt;
                            r_write <= reqWrite;
                            r_sel   <= w_sel;
                            r_wdata <= reqWrite ? reqWData : '0;
                            r_strb  <= reqWrite ? reqStrb : '0;
                        end else begin
                            r_state <= RESP;
                            r_rdata <= '0;
                            r_err   <= 1'b1;
                            r_to    <= 1'b0;
                        end
                    end
                end
                SETUP: r_state <= ACCESS;
                ACCESS: begin
                    // Completion wins over a timeout landing in the same cycle.
                    if (ready) begin
                        r_state <= RESP;
                        r_rdata <= r_write ? '0 : rData;
                        r_err   <= subError;
                        r_to    <= 1'b0;
                        r_sel   <= '0;
                    end else if ((TimeoutCycles != 0) && (r_wait == WaitLast)) begin
                        r_state <= RESP;
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_to    <= 1'b1;
                        r_sel   <= '0;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                RESP: begin
                    if (rspReady) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign reqReady   = (r_state == IDLE);
    assign rspValid   = (r_state == RESP);
    assign enable     = (r_state == ACCESS);
    assign selectors  = r_sel;
    assign addr       = r_addr;
    assign prot       = r_prot;
    assign write      = r_write;
    assign wData      = r_wdata;
    assign strb       = r_strb;
    assign rspRData   = r_rdata;
    assign rspError   = r_err;
    assign rspTimeout = r_to;

endmodule

// File: tb/tb_apb_manager_fsm.sv
// Randomized bench for apb_manager_fsm; expected timing/values come from a per-transaction model.
module tb_apb_manager_fsm;

    localparam logic [31:0] BASE   = 32'h0;
    localparam int          REGION = 4096;
    localparam int          NPRPH  = 4;
    localparam int          TO     = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid, reqReady, reqWrite;
    logic [31:0] reqAddr, reqWData;
    logic [3:0]  reqStrb, reqProt;
    logic        rspValid, rspReady, rspError, rspTimeout;
    logic [31:0] rspRData;
    logic [31:0] addr, wData, rData;
    logic [3:0]  prot, strb, selectors;
    logic        write, enable, ready, subError;

    int n_checks = 0;
    int n_errors = 0;

    // Model of the APB attribute outputs, which persist between transfers.
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_strb, m_prot;
    logic        m_write;

    always #5 clk = ~clk;

    apb_manager_fsm #(
        .AddrWidth(32), .DataWidth(32), .PrphNum(NPRPH), .BaseAddr(BASE),
        .RegionBits(12), .TimeoutCycles(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr), .reqWrite(reqWrite),
        .reqWData(reqWData), .reqStrb(reqStrb), .reqProt(reqProt),
        .rspValid(rspValid), .rspReady(rspReady), .rspRData(rspRData),
        .rspError(rspError), .rspTimeout(rspTimeout),
        .addr(addr), .prot(prot), .write(write), .wData(wData), .strb(strb),
        .selectors(selectors), .enable(enable),
        .ready(ready), .rData(rData), .subError(subError)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_attrs();
        check("addr",  addr,  m_addr);
        check("write", write, m_write);
        check("wData", wData, m_wdata);
        check("strb",  strb,  m_strb);
        check("prot",  prot,  m_prot);
    endtask

    task automatic run_txn(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                           input logic [3:0] st, input logic [3:0] pr, input int waits,
                           input logic serr, input logic [31:0] rd, input int hold);
        bit          hit, to, exp_err, in_access;
        int          rsp_k, idx, j;
        logic [3:0]  esel;
        logic [31:0] exp_rd;
        hit     = (a >= BASE) && (((a - BASE) / REGION) < NPRPH);
        idx     = hit ? int'((a - BASE) / REGION) : 0;
        esel    = hit ? (4'b0001 << idx) : 4'b0000;
        to      = hit && (waits >= TO);
        rsp_k   = !hit ? 1 : (to ? 2 + TO : 3 + waits);
        exp_err = !hit || to || serr;
        exp_rd  = (hit && !to && !wr) ? rd : 32'h0;

        @(negedge clk);
        check("reqReady_idle", reqReady, 1'b1);
        reqValid = 1'b1; reqAddr = a; reqWrite = wr; reqWData = wd; reqStrb = st; reqProt = pr;
        rspReady = 1'b0; ready = 1'b0;
        @(posedge clk);
        if (hit) begin
            m_addr  = a; m_write = wr; m_prot = pr;
            m_wdata = wr ? wd : 32'h0;
            m_strb  = wr ? st : 4'h0;
        end

        for (int k = 1; k <= rsp_k + hold; k++) begin
            @(negedge clk);
            in_access = hit && (k >= 2) && (k < rsp_k);
            check("rspValid",  rspValid,  k >= rsp_k);
            check("reqReady",  reqReady,  1'b0);
            check("enable",    enable,    in_access);
            check("selectors", selectors, (hit && k < rsp_k) ? esel : 4'b0000);
            check_attrs();
            if (k >= rsp_k) begin
                check("rspError",   rspError,   exp_err);
                check("rspTimeout", rspTimeout, to);
                check("rspRData",   rspRData,   exp_rd);
            end
            // Junk on the request side must never be captured while busy.
            if (k < rsp_k + hold) begin
                reqValid = 1'($urandom); reqAddr = $urandom; reqWrite = 1'($urandom);
                reqWData = $urandom; reqStrb = 4'($urandom); reqProt = 4'($urandom);
            end else begin
                reqValid = 1'b0;
            end
            j = k - 2;
            if (in_access && j == waits) begin
                ready = 1'b1; rData = rd; subError = serr;
            end else begin
                ready = in_access ? 1'b0 : 1'($urandom);
                rData = $urandom; subError = 1'($urandom);
            end
            rspReady = (k >= rsp_k + hold);
        end
    endtask

    task automatic check_zeroed(input string tag);
        check({tag, "_selectors"}, selectors, 4'h0);
        check({tag, "_enable"},    enable,    1'b0);
        check({tag, "_rspValid"},  rspValid,  1'b0);
        check({tag, "_reqReady"},  reqReady,  1'b1);
        check({tag, "_rspError"},  rspError,  1'b0);
        check({tag, "_rspRData"},  rspRData,  32'h0);
        check_attrs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra;
        int          rw;
        reset = 1'b1; reqValid = 1'b0; reqAddr = '0; reqWrite = 1'b0; reqWData = '0;
        reqStrb = '0; reqProt = '0; rspReady = 1'b0; ready = 1'b0; rData = '0; subError = 1'b0;
        m_addr = '0; m_wdata = '0; m_strb = '0; m_prot = '0; m_write = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_zeroed("reset");

        run_txn(32'h1004, 1'b1, 32'hDEADBEEF, 4'hF, 4'h2, 0,  1'b0, 32'h0,        0);
        run_txn(32'h3010, 1'b0, 32'hAAAA5555, 4'hF, 4'h1, 2,  1'b0, 32'h12345678, 0);
        run_txn(32'h4000, 1'b0, 32'h0,        4'h0, 4'h0, 0,  1'b0, 32'h0,        0);
        run_txn(32'h2000, 1'b0, 32'h0,        4'h0, 4'h3, TO, 1'b0, 32'hCAFEF00D, 0);
        run_txn(32'h0008, 1'b0, 32'h0,        4'h0, 4'h0, TO - 1, 1'b0, 32'h55AA33CC, 0);
        run_txn(32'h2100, 1'b1, 32'h01020304, 4'h5, 4'h4, 0,  1'b1, 32'h0,        5);

        // Reset while in ACCESS drops the transfer.
        @(negedge clk);
        check("reqReady_pre_rst", reqReady, 1'b1);
        reqValid = 1'b1; reqAddr = 32'h3ABC; reqWrite = 1'b1; reqWData = 32'h77; reqStrb = 4'h3;
        reqProt = 4'h6; ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        @(negedge clk);
        check("enable_pre_rst",    enable,    1'b1);
        check("selectors_pre_rst", selectors, 4'b1000);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_addr = '0; m_wdata = '0; m_strb = '0; m_prot = '0; m_write = 1'b0;
        check_zeroed("midrst");
        run_txn(32'h0000, 1'b1, 32'h89ABCDEF, 4'hC, 4'h0, 1, 1'b0, 32'h0, 0);

        for (int t = 0; t < 60; t++) begin
            rw = $urandom_range(0, 9);
            ra = (rw < 7) ? 32'($urandom_range(0, 32'h4FFF)) : $urandom;
            run_txn(ra, 1'($urandom), $urandom, 4'($urandom), 4'($urandom),
                    ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 3),
                    1'($urandom_range(0, 4) == 0), $urandom, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
